// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: central stall/flush sequencer for the 5-stage pipeline.
// Handles load-use hazards in ID, taken redirects in EX and data-memory waits in MEM.
// Define PIPE_HAZARD_PERF_EN to build the saturating performance counters;
// without it perf_stall_cnt/perf_flush_cnt are tied to zero and no counter flops exist.
module pipe_hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned BR_PENALTY  = 1,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs1addr,
  input  logic [4:0]       id_rs2addr,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [4:0]       ex_rdaddr,
  input  logic             ex_regwr,
  input  logic             ex_isload,
  input  logic             ex_redirect,
  input  logic             dmem_req,
  input  logic             dmem_ack,
  output logic             pc_stall,
  output logic             if_id_stall,
  output logic             if_id_flush,
  output logic             id_ex_stall,
  output logic             id_ex_flush,
  output logic             ex_mem_stall,
  output logic             mem_wb_bubble,
  output logic             mem_err,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] perf_stall_cnt,
  output logic [CNT_W-1:0] perf_flush_cnt
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LDUSE    = 2'd1,
    MEM_WAIT = 2'd2,
    FLUSH    = 2'd3
  } state_e;

  // Last wait-counter value before the outstanding memory access is abandoned.
  localparam logic [7:0] WaitLast   = 8'(MEM_TIMEOUT - 1);
  // Extra IF/ID flush cycles after the redirect cycle itself.
  localparam logic [2:0] FlushLoad  = 3'(BR_PENALTY - 1);
  localparam bit         MultiFlush = (BR_PENALTY > 1);

  state_e     state_q, state_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic [2:0] flush_cnt_q, flush_cnt_d;
  logic       mem_err_q, mem_err_d;
  logic       load_use_hz;
  logic       mem_wait_req;

  assign load_use_hz  = ex_regwr & ex_isload & (ex_rdaddr != 5'd0) &
                        ((id_uses_rs1 & (id_rs1addr == ex_rdaddr)) |
                         (id_uses_rs2 & (id_rs2addr == ex_rdaddr)));
  assign mem_wait_req = dmem_req & ~dmem_ack;

  // Next-state and control outputs: memwait beats redirect beats load-use.
  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    flush_cnt_d   = flush_cnt_q;
    mem_err_d     = 1'b0;
    pc_stall      = 1'b0;
    if_id_stall   = 1'b0;
    if_id_flush   = 1'b0;
    id_ex_stall   = 1'b0;
    id_ex_flush   = 1'b0;
    ex_mem_stall  = 1'b0;
    mem_wb_bubble = 1'b0;

    case (state_q)
      MEM_WAIT: begin
        if (dmem_ack) begin
          state_d    = RUN;
          wait_cnt_d = 8'd0;
        end else begin
          pc_stall      = 1'b1;
          if_id_stall   = 1'b1;
          id_ex_stall   = 1'b1;
          ex_mem_stall  = 1'b1;
          mem_wb_bubble = 1'b1;
          if (wait_cnt_q == WaitLast) begin
            state_d    = RUN;
            wait_cnt_d = 8'd0;
            mem_err_d  = 1'b1;
          end else begin
            wait_cnt_d = wait_cnt_q + 8'd1;
          end
        end
      end
      default: begin
        if (mem_wait_req) begin
          pc_stall      = 1'b1;
          if_id_stall   = 1'b1;
          id_ex_stall   = 1'b1;
          ex_mem_stall  = 1'b1;
          mem_wb_bubble = 1'b1;
          state_d       = MEM_WAIT;
          wait_cnt_d    = 8'd1;
          flush_cnt_d   = 3'd0;
        end else if (ex_redirect) begin
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
          if (MultiFlush) begin
            state_d     = FLUSH;
            flush_cnt_d = FlushLoad;
          end else begin
            state_d = RUN;
          end
        end else if (state_q == FLUSH) begin
          if_id_flush = 1'b1;
          if (flush_cnt_q <= 3'd1) begin
            state_d     = RUN;
            flush_cnt_d = 3'd0;
          end else begin
            flush_cnt_d = flush_cnt_q - 3'd1;
          end
        end else if (load_use_hz && (state_q == RUN)) begin
          pc_stall    = 1'b1;
          if_id_stall = 1'b1;
          id_ex_stall = 1'b1;
          state_d     = LDUSE;
        end else begin
          state_d = RUN;
        end
      end
    endcase
  end

  // State, wait/flush counters and the registered abort pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      wait_cnt_q  <= 8'd0;
      flush_cnt_q <= 3'd0;
      mem_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      mem_err_q   <= mem_err_d;
    end
  end

  assign state_o = state_q;
  assign mem_err = mem_err_q;

`ifdef PIPE_HAZARD_PERF_EN
  logic [CNT_W-1:0] perf_stall_q;
  logic [CNT_W-1:0] perf_flush_q;

  // Saturating counters: PC-held cycles and redirects actually taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else begin
      if (pc_stall && (perf_stall_q != {CNT_W{1'b1}})) begin
        perf_stall_q <= perf_stall_q + CNT_W'(1);
      end
      if (id_ex_flush && (perf_flush_q != {CNT_W{1'b1}})) begin
        perf_flush_q <= perf_flush_q + CNT_W'(1);
      end
    end
  end

  assign perf_stall_cnt = perf_stall_q;
  assign perf_flush_cnt = perf_flush_q;
`else
  assign perf_stall_cnt = '0;
  assign perf_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed vector table, multi-cycle corner sequences and a
// randomized run checked against a behavioural model of the hazard rules.
module tb_pipe_hazard_ctrl;

  localparam int MEM_TIMEOUT = 16;
  localparam int BR_PENALTY  = 3;
  localparam int CNT_W       = 4;
  localparam int CntMax      = (1 << CNT_W) - 1;

`ifdef PIPE_HAZARD_PERF_EN
  localparam logic [CNT_W-1:0] PerfMask = '1;
`else
  localparam logic [CNT_W-1:0] PerfMask = '0;
`endif

  // Control bit order: pc, ifIdStall, ifIdFlush, idExStall, idExFlush, exMemStall, memWbBubble
  localparam logic [6:0] CtlNone   = 7'b0000000;
  localparam logic [6:0] CtlStall3 = 7'b1101000;
  localparam logic [6:0] CtlStall5 = 7'b1101011;
  localparam logic [6:0] CtlFlush2 = 7'b0010100;
  localparam logic [6:0] CtlFlush1 = 7'b0010000;

  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       useRs1;
    logic       useRs2;
    logic [4:0] rd;
    logic       regWr;
    logic       isLoad;
    logic       redirect;
    logic       req;
    logic       ack;
  } inVec_t;

  typedef struct packed {
    logic [6:0]       ctl;
    logic             memErr;
    logic [1:0]       state;
    logic [CNT_W-1:0] stallCnt;
    logic [CNT_W-1:0] flushCnt;
  } outVec_t;

  typedef struct {
    string   name;
    inVec_t  stim;
    outVec_t want;
  } vecRec_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [4:0]       id_rs1addr, id_rs2addr, ex_rdaddr;
  logic             id_uses_rs1, id_uses_rs2, ex_regwr, ex_isload, ex_redirect;
  logic             dmem_req, dmem_ack;
  logic             pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush;
  logic             ex_mem_stall, mem_wb_bubble, mem_err;
  logic [1:0]       state_o;
  logic [CNT_W-1:0] perf_stall_cnt, perf_flush_cnt;
  outVec_t          dutOut;

  int vectors     = 0;
  int miscompares = 0;

  // Behavioural model: stall cycles spent on the current access, flush cycles left,
  // whether the load-use bubble was just issued, and the pending abort pulse.
  int mStalls, mFlushLeft, mStallCnt, mFlushCnt;
  bit mBubbled, mErr;

  pipe_hazard_ctrl #(
    .MEM_TIMEOUT(MEM_TIMEOUT),
    .BR_PENALTY (BR_PENALTY),
    .CNT_W      (CNT_W)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .id_rs1addr    (id_rs1addr),
    .id_rs2addr    (id_rs2addr),
    .id_uses_rs1   (id_uses_rs1),
    .id_uses_rs2   (id_uses_rs2),
    .ex_rdaddr     (ex_rdaddr),
    .ex_regwr      (ex_regwr),
    .ex_isload     (ex_isload),
    .ex_redirect   (ex_redirect),
    .dmem_req      (dmem_req),
    .dmem_ack      (dmem_ack),
    .pc_stall      (pc_stall),
    .if_id_stall   (if_id_stall),
    .if_id_flush   (if_id_flush),
    .id_ex_stall   (id_ex_stall),
    .id_ex_flush   (id_ex_flush),
    .ex_mem_stall  (ex_mem_stall),
    .mem_wb_bubble (mem_wb_bubble),
    .mem_err       (mem_err),
    .state_o       (state_o),
    .perf_stall_cnt(perf_stall_cnt),
    .perf_flush_cnt(perf_flush_cnt)
  );

  assign dutOut = {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
                   ex_mem_stall, mem_wb_bubble, mem_err, state_o, perf_stall_cnt, perf_flush_cnt};

  always #5 clk = ~clk;

  // Hard stop in case the sequence ever stalls.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, want summary before 200000ns");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [CNT_W-1:0] perfView(input int c);
    return CNT_W'(c) & PerfMask;
  endfunction

  function automatic inVec_t mkIn(input logic ld, input logic [4:0] rd, input logic useRs2,
                                  input logic [4:0] rs2, input logic redir, input logic req,
                                  input logic ack);
    inVec_t v;
    v = '0;
    v.isLoad = ld;
    v.regWr = ld;
    v.rd = rd;
    v.useRs2 = useRs2;
    v.rs2 = rs2;
    v.redirect = redir;
    v.req = req;
    v.ack = ack;
    return v;
  endfunction

  function automatic outVec_t mkOut(input logic [6:0] ctl, input logic err, input logic [1:0] st,
                                    input int sc, input int fc);
    outVec_t o;
    o.ctl = ctl;
    o.memErr = err;
    o.state = st;
    o.stallCnt = perfView(sc);
    o.flushCnt = perfView(fc);
    return o;
  endfunction

  function automatic bit modelHazard(input inVec_t v);
    return v.regWr && v.isLoad && (v.rd != 5'd0) &&
           ((v.useRs1 && (v.rs1 == v.rd)) || (v.useRs2 && (v.rs2 == v.rd)));
  endfunction

  function automatic void modelReset();
    mStalls = 0;
    mFlushLeft = 0;
    mBubbled = 0;
    mErr = 0;
    mStallCnt = 0;
    mFlushCnt = 0;
  endfunction

  // What the controller should show this cycle given the model history and inputs.
  function automatic outVec_t modelOutputs(input inVec_t v);
    outVec_t o;
    o = '0;
    o.memErr = mErr;
    o.state = (mStalls > 0) ? 2'd2 : (mFlushLeft > 0) ? 2'd3 : mBubbled ? 2'd1 : 2'd0;
    o.stallCnt = perfView(mStallCnt);
    o.flushCnt = perfView(mFlushCnt);
    if (mStalls > 0) begin
      if (!v.ack) o.ctl = CtlStall5;
    end else if (v.req && !v.ack) begin
      o.ctl = CtlStall5;
    end else if (v.redirect) begin
      o.ctl = CtlFlush2;
    end else if (mFlushLeft > 0) begin
      o.ctl = CtlFlush1;
    end else if (modelHazard(v) && !mBubbled) begin
      o.ctl = CtlStall3;
    end
    return o;
  endfunction

  // Advance the model by one clock edge.
  function automatic void modelAdvance(input inVec_t v);
    outVec_t o;
    bit errNext;
    o = modelOutputs(v);
    errNext = 0;
    if (o.ctl[6] && (mStallCnt < CntMax)) mStallCnt++;
    if (o.ctl[2] && (mFlushCnt < CntMax)) mFlushCnt++;
    if (mStalls > 0) begin
      if (v.ack) begin
        mStalls = 0;
      end else if (mStalls + 1 == MEM_TIMEOUT) begin
        mStalls = 0;
        errNext = 1;
      end else begin
        mStalls++;
      end
    end else if (v.req && !v.ack) begin
      mStalls = 1;
      mFlushLeft = 0;
      mBubbled = 0;
    end else if (v.redirect) begin
      mFlushLeft = BR_PENALTY - 1;
      mBubbled = 0;
    end else if (mFlushLeft > 0) begin
      mFlushLeft--;
    end else begin
      mBubbled = modelHazard(v) && !mBubbled;
    end
    mErr = errNext;
  endfunction

  task automatic driveInputs(input inVec_t v);
    id_rs1addr  = v.rs1;
    id_rs2addr  = v.rs2;
    id_uses_rs1 = v.useRs1;
    id_uses_rs2 = v.useRs2;
    ex_rdaddr   = v.rd;
    ex_regwr    = v.regWr;
    ex_isload   = v.isLoad;
    ex_redirect = v.redirect;
    dmem_req    = v.req;
    dmem_ack    = v.ack;
  endtask

  task automatic checkOutput(input string name, input outVec_t want);
    vectors++;
    if (dutOut !== want) begin
      miscompares++;
      $display("[TB] FAIL %s: got ctl=%b err=%b st=%0d sc=%0d fc=%0d, want ctl=%b err=%b st=%0d sc=%0d fc=%0d",
               name, dutOut.ctl, dutOut.memErr, dutOut.state, dutOut.stallCnt, dutOut.flushCnt,
               want.ctl, want.memErr, want.state, want.stallCnt, want.flushCnt);
    end
  endtask

  // Called just after a rising edge; checks on the falling edge, ends just after the next rising edge.
  task automatic applyStimulus(input string name, input inVec_t v, input outVec_t want);
    driveInputs(v);
    @(negedge clk);
    checkOutput(name, want);
    modelAdvance(v);
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset from whatever state the controller is in.
  task automatic resetCheck(input string name);
    driveInputs('0);
    rst_n = 1'b0;
    #2;
    modelReset();
    checkOutput(name, outVec_t'('0));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  vecRec_t vecs[$];
  inVec_t  idle, hzIn, redirIn, reqIn, ackIn, rv;

  initial begin
    idle    = '0;
    hzIn    = mkIn(1'b1, 5'd5, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
    redirIn = mkIn(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
    reqIn   = mkIn(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    ackIn   = mkIn(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);

    // Directed table, applied back to back from reset.
    vecs.push_back('{"ldUseStall",      hzIn, mkOut(CtlStall3, 0, 2'd0, 0, 0)});
    vecs.push_back('{"ldUseNoRedetect", hzIn, mkOut(CtlNone,   0, 2'd1, 1, 0)});
    vecs.push_back('{"ldUseBackToRun",  idle, mkOut(CtlNone,   0, 2'd0, 1, 0)});
    vecs.push_back('{"rdZeroNoStall",   mkIn(1, 0, 1, 0, 0, 0, 0), mkOut(CtlNone, 0, 2'd0, 1, 0)});
    vecs.push_back('{"redirectFirst",   redirIn, mkOut(CtlFlush2, 0, 2'd0, 1, 0)});
    vecs.push_back('{"flushSecond",     idle, mkOut(CtlFlush1, 0, 2'd3, 1, 1)});
    vecs.push_back('{"flushThird",      idle, mkOut(CtlFlush1, 0, 2'd3, 1, 1)});
    vecs.push_back('{"flushDone",       idle, mkOut(CtlNone,   0, 2'd0, 1, 1)});
    vecs.push_back('{"memWaitEnter",    reqIn, mkOut(CtlStall5, 0, 2'd0, 1, 1)});
    for (int k = 0; k < 4; k++) begin
      vecs.push_back('{"memWaitHold",   reqIn, mkOut(CtlStall5, 0, 2'd2, 2 + k, 1)});
    end
    vecs.push_back('{"memAckDrop",      ackIn, mkOut(CtlNone,   0, 2'd2, 6, 1)});
    vecs.push_back('{"afterAck",        idle, mkOut(CtlNone,   0, 2'd0, 6, 1)});
    vecs.push_back('{"memBeatsRedir",   mkIn(1, 5, 1, 5, 1, 1, 0), mkOut(CtlStall5, 0, 2'd0, 6, 1)});
    vecs.push_back('{"memWaitIgnRedir", mkIn(1, 5, 1, 5, 1, 1, 0), mkOut(CtlStall5, 0, 2'd2, 7, 1)});
    vecs.push_back('{"ackIgnRedir",     mkIn(1, 5, 1, 5, 1, 1, 1), mkOut(CtlNone,   0, 2'd2, 8, 1)});
    vecs.push_back('{"redirAfterAck",   mkIn(1, 5, 1, 5, 1, 0, 0), mkOut(CtlFlush2, 0, 2'd0, 8, 1)});
    vecs.push_back('{"flushAfterAck",   idle, mkOut(CtlFlush1, 0, 2'd3, 8, 2)});
    vecs.push_back('{"memPreemptFlush", reqIn, mkOut(CtlStall5, 0, 2'd3, 8, 2)});
    vecs.push_back('{"preemptAck",      ackIn, mkOut(CtlNone,   0, 2'd2, 9, 2)});
    vecs.push_back('{"flushDropped",    idle, mkOut(CtlNone,   0, 2'd0, 9, 2)});
    vecs.push_back('{"redirReloadA",    redirIn, mkOut(CtlFlush2, 0, 2'd0, 9, 2)});
    vecs.push_back('{"redirReloadB",    redirIn, mkOut(CtlFlush2, 0, 2'd3, 9, 3)});
    vecs.push_back('{"reloadFlush1",    idle, mkOut(CtlFlush1, 0, 2'd3, 9, 4)});
    vecs.push_back('{"reloadFlush2",    idle, mkOut(CtlFlush1, 0, 2'd3, 9, 4)});
    vecs.push_back('{"reloadDone",      idle, mkOut(CtlNone,   0, 2'd0, 9, 4)});

    resetCheck("resetState");

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].name, vecs[i].stim, vecs[i].want);
    end

    // Timeout: sixteen stall cycles without ack, then a single-cycle abort pulse.
    for (int k = 0; k < MEM_TIMEOUT; k++) begin
      applyStimulus("timeoutStall", reqIn,
                    mkOut(CtlStall5, 0, (k == 0) ? 2'd0 : 2'd2, (9 + k > CntMax) ? CntMax : 9 + k, 4));
    end
    applyStimulus("timeoutErr",   idle, mkOut(CtlNone, 1, 2'd0, CntMax, 4));
    applyStimulus("errOneShot",   idle, mkOut(CtlNone, 0, 2'd0, CntMax, 4));

    // Reset while waiting on memory and while flushing.
    applyStimulus("preResetWaitA", reqIn, modelOutputs(reqIn));
    applyStimulus("preResetWaitB", reqIn, modelOutputs(reqIn));
    resetCheck("resetInWait");
    applyStimulus("preResetRedir", redirIn, modelOutputs(redirIn));
    resetCheck("resetInFlush");
    applyStimulus("postResetIdle", idle, mkOut(CtlNone, 0, 2'd0, 0, 0));

    // Randomized traffic against the behavioural model.
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        resetCheck("randReset");
      end else begin
        rv.rs1      = 5'($urandom_range(0, 3));
        rv.rs2      = 5'($urandom_range(0, 3));
        rv.useRs1   = 1'($urandom_range(0, 1));
        rv.useRs2   = 1'($urandom_range(0, 1));
        rv.rd       = 5'($urandom_range(0, 3));
        rv.regWr    = ($urandom_range(0, 3) != 0);
        rv.isLoad   = 1'($urandom_range(0, 1));
        rv.redirect = ($urandom_range(0, 6) == 0);
        rv.req      = ($urandom_range(0, 2) == 0);
        rv.ack      = ($urandom_range(0, 2) == 0);
        applyStimulus("randVec", rv, modelOutputs(rv));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
